// File: rtl/calc_pkg.sv
// Shared calculator constants: default datapath sizes, converter state encoding and the
// digit-count width also used by the 7-segment display driver.
package calc_pkg;

    localparam int unsigned WIDTH_DEF  = 32;
    localparam int unsigned DIGITS_DEF = 10;
    localparam int unsigned NDIG_W     = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit corrector: adds 3 to a BCD digit of 5 or more ahead of the shift.
module bcd_digit_adj (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    always_comb begin
        digit_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_o = digit_i + 4'd3;
        end
    end

endmodule

// File: rtl/result_bcd_conv.sv
// Signed binary to packed BCD converter, one double-dabble step per clock, with sign flag and
// significant-digit count for leading-zero blanking on the display.
module result_bcd_conv
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH  = WIDTH_DEF,
    parameter int unsigned DIGITS = DIGITS_DEF
) (
    input  logic                  sw_clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [WIDTH-1:0]      value,
    output logic                  busy,
    output logic                  done,
    output logic                  neg,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [NDIG_W-1:0]     ndig
);

    localparam int unsigned BW   = 4 * DIGITS;
    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] One  = WIDTH'(1);
    localparam logic [CntW-1:0]  Last = CntW'(WIDTH - 1);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    mag_q, mag_d;
    logic [BW-1:0]       scr_q, scr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                sign_q, sign_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                neg_q, neg_d;
    logic [BW-1:0]       bcd_q, bcd_d;
    logic [NDIG_W-1:0]   ndig_q, ndig_d;

    logic [BW-1:0]       adj;
    logic [BW-1:0]       scr_shift;
    logic [NDIG_W-1:0]   ndig_fin;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit_i (scr_q[4*g +: 4]),
            .digit_o (adj[4*g +: 4])
        );
    end

    assign scr_shift = {adj[BW-2:0], mag_q[WIDTH-1]};

    // Highest nonzero digit of the final scratch; an all-zero result still shows one digit.
    always_comb begin
        ndig_fin = NDIG_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_shift[4*i +: 4] != 4'd0) begin
                ndig_fin = NDIG_W'(i + 1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        mag_d   = mag_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        sign_d  = sign_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        neg_d   = neg_q;
        bcd_d   = bcd_q;
        ndig_d  = ndig_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    sign_d  = value[WIDTH-1];
                    // Unsigned negate keeps the most negative input exact.
                    mag_d   = value[WIDTH-1] ? (~value + One) : value;
                    scr_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SHIFT: begin
                scr_d = scr_shift;
                mag_d = {mag_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == Last) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    bcd_d   = scr_shift;
                    neg_d   = sign_q;
                    ndig_d  = ndig_fin;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge sw_clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mag_q   <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            neg_q   <= 1'b0;
            bcd_q   <= '0;
            ndig_q  <= NDIG_W'(1);
        end else begin
            state_q <= state_d;
            mag_q   <= mag_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            neg_q   <= neg_d;
            bcd_q   <= bcd_d;
            ndig_q  <= ndig_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign neg  = neg_q;
    assign bcd  = bcd_q;
    assign ndig = ndig_q;

endmodule
